// File: rtl/lc3b_decode_stage.sv
// LC-3b decode stage: decodes into a control word, holds it in a one-entry
// pipeline register and stalls instructions that read registers with loads still in flight.
package lc3b_decode_pkg;

  typedef enum logic [2:0] {
    alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
  } lc3b_aluop;

  typedef struct packed {
    logic [3:0] opcode;
    lc3b_aluop  alu_op;
    logic       load_regfile;
    logic       load_cc;
    logic       load_mar;
    logic       load_mdr;
    logic       mem_read;
    logic       mem_write;
    logic       storemux_sel_two;
    logic [1:0] alumux_sel;
    logic [1:0] mdrmux_sel;
    logic [2:0] regfilemux_sel;
    logic [1:0] mem_byte_enable;
  } lc3b_control_word;

  localparam logic [3:0] op_br  = 4'b0000;
  localparam logic [3:0] op_add = 4'b0001;
  localparam logic [3:0] op_and = 4'b0101;
  localparam logic [3:0] op_ldr = 4'b0110;
  localparam logic [3:0] op_str = 4'b0111;
  localparam logic [3:0] op_not = 4'b1001;
  localparam logic [3:0] op_shf = 4'b1101;

endpackage

module lc3b_decode_stage
  import lc3b_decode_pkg::*;
#(
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned LOAD_LAT     = 2,
  parameter int unsigned ILLEGAL_FLAG = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD_W-1:0] in_inst,
  input  logic [WORD_W-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WORD_W-1:0] out_inst,
  output logic [WORD_W-1:0] out_pc,
  output lc3b_control_word out_ctrl,
  output logic             out_illegal,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int unsigned NREG = 8;
  localparam int unsigned SB_W = 3;

  lc3b_control_word dec_ctrl;
  logic             dec_illegal;
  logic             dec_is_ldr;
  logic             use_a, use_b, use_all;
  logic [2:0]       src_a, src_b;
  logic [NREG-1:0]  pend;
  logic             hazard;
  logic             accept;

  logic [NREG-1:0][SB_W-1:0] cnt_q, cnt_d;
  logic                      valid_q, valid_d;
  logic [WORD_W-1:0]         inst_q, inst_d;
  logic [WORD_W-1:0]         pc_q, pc_d;
  lc3b_control_word          ctrl_q, ctrl_d;
  logic                      illegal_q, illegal_d;
  logic [CNT_W-1:0]          stall_q, stall_d;

  // Instruction decode and source-register selection.
  always_comb begin
    dec_ctrl                 = '0;
    dec_ctrl.opcode          = in_inst[15:12];
    dec_ctrl.mem_byte_enable = 2'b11;
    dec_ctrl.alu_op          = alu_add;
    dec_illegal              = 1'b0;
    dec_is_ldr               = 1'b0;
    src_a                    = in_inst[8:6];
    src_b                    = in_inst[2:0];
    use_a                    = 1'b0;
    use_b                    = 1'b0;
    use_all                  = 1'b0;
    case (in_inst[15:12])
      op_add, op_and: begin
        dec_ctrl.alu_op       = (in_inst[15:12] == op_and) ? alu_and : alu_add;
        dec_ctrl.load_regfile = 1'b1;
        dec_ctrl.load_cc      = 1'b1;
        if (in_inst[5]) dec_ctrl.alumux_sel = 2'b10;
        use_a                 = 1'b1;
        use_b                 = !in_inst[5];
      end
      op_not: begin
        dec_ctrl.alu_op       = alu_not;
        dec_ctrl.load_regfile = 1'b1;
        dec_ctrl.load_cc      = 1'b1;
        use_a                 = 1'b1;
      end
      op_ldr: begin
        dec_ctrl.alumux_sel     = 2'b01;
        dec_ctrl.load_mar       = 1'b1;
        dec_ctrl.mdrmux_sel     = 2'b01;
        dec_ctrl.load_mdr       = 1'b1;
        dec_ctrl.mem_read       = 1'b1;
        dec_ctrl.regfilemux_sel = 3'b001;
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.load_cc        = 1'b1;
        dec_is_ldr              = 1'b1;
        use_a                   = 1'b1;
      end
      op_str: begin
        dec_ctrl.alumux_sel       = 2'b01;
        dec_ctrl.load_mar         = 1'b1;
        dec_ctrl.mdrmux_sel       = 2'b11;
        dec_ctrl.storemux_sel_two = 1'b1;
        dec_ctrl.mem_write        = 1'b1;
        src_b                     = in_inst[11:9];
        use_a                     = 1'b1;
        use_b                     = 1'b1;
      end
      op_br: begin
        use_all = 1'b1;
      end
      op_shf: begin
        dec_ctrl.regfilemux_sel = 3'b101;
        dec_ctrl.load_regfile   = 1'b1;
        use_a                   = 1'b1;
      end
      default: begin
        dec_ctrl    = '0;
        dec_illegal = (ILLEGAL_FLAG != 0);
      end
    endcase
  end

  // Hazard detection and input handshake.
  always_comb begin
    for (int r = 0; r < NREG; r++) pend[r] = (cnt_q[r] != '0);
    hazard   = in_valid & ((use_a & pend[src_a]) | (use_b & pend[src_b]) | (use_all & (|pend)));
    in_ready = (!valid_q | out_ready) & !hazard & !flush;
    accept   = in_valid & in_ready;
  end

  // Load scoreboard: a fresh load overrides the countdown, flush clears everything.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - SB_W'(1);
      if (accept && dec_is_ldr && (in_inst[11:9] == 3'(r))) cnt_d[r] = SB_W'(LOAD_LAT);
      if (flush) cnt_d[r] = '0;
    end
  end

  // Output register and stall counter next state.
  always_comb begin
    valid_d   = valid_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    stall_d   = stall_q;
    if (hazard && !flush && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      inst_d    = in_inst;
      pc_d      = in_pc;
      ctrl_d    = dec_ctrl;
      illegal_d = dec_illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      pc_q      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_inst     = inst_q;
  assign out_pc       = pc_q;
  assign out_ctrl     = ctrl_q;
  assign out_illegal  = illegal_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_lc3b_decode_stage.sv
// Directed bench for lc3b_decode_stage: decode values, load-use stalls,
// backpressure, flush, illegal opcodes and asynchronous reset.
module tb_lc3b_decode_stage;
  import lc3b_decode_pkg::*;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_inst;
  logic [WORD_W-1:0] in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_inst;
  logic [WORD_W-1:0] out_pc;
  lc3b_control_word  out_ctrl;
  logic              out_illegal;
  logic [CNT_W-1:0]  stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  lc3b_decode_stage #(
    .WORD_W(WORD_W), .LOAD_LAT(2), .ILLEGAL_FLAG(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction encodings
  localparam logic [15:0] I_ADD_R  = 16'h1283; // ADD R1,R2,R3
  localparam logic [15:0] I_ADD_I  = 16'h12A5; // ADD R1,R2,#5
  localparam logic [15:0] I_AND    = 16'h5946; // AND R4,R5,R6
  localparam logic [15:0] I_NOT    = 16'h94FF; // NOT R2,R3
  localparam logic [15:0] I_SHF    = 16'hD281; // SHF R1,R2,#1
  localparam logic [15:0] I_BR     = 16'h0E02; // BRnzp
  localparam logic [15:0] I_LDR3   = 16'h6600; // LDR R3,R0,#0
  localparam logic [15:0] I_LDR5   = 16'h6A00; // LDR R5,R0,#0
  localparam logic [15:0] I_ADD_D  = 16'h12C2; // ADD R1,R3,R2 (uses R3)
  localparam logic [15:0] I_ADD_N  = 16'h1302; // ADD R1,R4,R2 (independent)
  localparam logic [15:0] I_STR5   = 16'h7A40; // STR R5,R1,#0
  localparam logic [15:0] I_ILL    = 16'h8000;

  // flags = {load_regfile, load_cc, load_mar, load_mdr, mem_read, mem_write, storemux_sel_two}
  function automatic lc3b_control_word cw(input logic [3:0] op, input lc3b_aluop alu,
                                          input logic [6:0] f, input logic [1:0] amux,
                                          input logic [1:0] mmux, input logic [2:0] rmux);
    lc3b_control_word c;
    c = '0;
    c.opcode = op;
    c.alu_op = alu;
    {c.load_regfile, c.load_cc, c.load_mar, c.load_mdr, c.mem_read, c.mem_write,
     c.storemux_sel_two} = f;
    c.alumux_sel      = amux;
    c.mdrmux_sel      = mmux;
    c.regfilemux_sel  = rmux;
    c.mem_byte_enable = 2'b11;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk(tag, 32'(in_ready), 32'(exp));
  endtask

  task automatic chk_stall(input string tag, input int exp);
    chk(tag, 32'(stall_cycles), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic [15:0] inst, input logic [15:0] pc,
                         input lc3b_control_word c, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".inst"}, 32'(out_inst), 32'(inst));
    chk({tag, ".pc"}, 32'(out_pc), 32'(pc));
    chk({tag, ".ctrl"}, 32'(out_ctrl), 32'(c));
    chk({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".inst"}, 32'(out_inst), 32'd0);
    chk({tag, ".pc"}, 32'(out_pc), 32'd0);
    chk({tag, ".ctrl"}, 32'(out_ctrl), 32'd0);
    chk({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    chk({tag, ".stall"}, 32'(stall_cycles), 32'd0);
  endtask

  initial begin
    lc3b_control_word c_add, c_addi, c_and, c_not, c_shf, c_br, c_ldr, c_str;
    c_add  = cw(4'h1, alu_add, 7'b1100000, 2'b00, 2'b00, 3'b000);
    c_addi = cw(4'h1, alu_add, 7'b1100000, 2'b10, 2'b00, 3'b000);
    c_and  = cw(4'h5, alu_and, 7'b1100000, 2'b00, 2'b00, 3'b000);
    c_not  = cw(4'h9, alu_not, 7'b1100000, 2'b00, 2'b00, 3'b000);
    c_shf  = cw(4'hD, alu_add, 7'b1000000, 2'b00, 2'b00, 3'b101);
    c_br   = cw(4'h0, alu_add, 7'b0000000, 2'b00, 2'b00, 3'b000);
    c_ldr  = cw(4'h6, alu_add, 7'b1111100, 2'b01, 2'b01, 3'b001);
    c_str  = cw(4'h7, alu_add, 7'b0010011, 2'b01, 2'b11, 3'b000);

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #3;
    chk_zero("reset");
    @(posedge clk);
    #3;
    reset_n = 1'b1;

    // Back-to-back stream, one entry per cycle
    drive(1'b1, I_ADD_R, 16'h3000); chk_ready("rdy_add", 1'b1); tick();
    chk_out("add", I_ADD_R, 16'h3000, c_add, 1'b0);
    drive(1'b1, I_ADD_I, 16'h3002); chk_ready("rdy_addi", 1'b1); tick();
    chk_out("addi", I_ADD_I, 16'h3002, c_addi, 1'b0);
    drive(1'b1, I_AND, 16'h3004); chk_ready("rdy_and", 1'b1); tick();
    chk_out("and", I_AND, 16'h3004, c_and, 1'b0);
    drive(1'b1, I_NOT, 16'h3006); chk_ready("rdy_not", 1'b1); tick();
    chk_out("not", I_NOT, 16'h3006, c_not, 1'b0);
    drive(1'b1, I_SHF, 16'h3008); chk_ready("rdy_shf", 1'b1); tick();
    chk_out("shf", I_SHF, 16'h3008, c_shf, 1'b0);
    drive(1'b1, I_BR, 16'h300A); chk_ready("rdy_br", 1'b1); tick();
    chk_out("br", I_BR, 16'h300A, c_br, 1'b0);
    drive(1'b0, '0, '0); tick();
    chk("bubble.valid", 32'(out_valid), 32'd0);

    // Load-use: two stall cycles, dependent ADD accepted on the third
    drive(1'b1, I_LDR3, 16'h3100); chk_ready("rdy_ldr3", 1'b1); tick();
    chk_out("ldr3", I_LDR3, 16'h3100, c_ldr, 1'b0);
    drive(1'b1, I_ADD_D, 16'h3102); chk_ready("lu.stall1", 1'b0); tick();
    chk("lu.bubble", 32'(out_valid), 32'd0);
    chk_stall("lu.cnt1", 1);
    chk_ready("lu.stall2", 1'b0); tick();
    chk_stall("lu.cnt2", 2);
    chk_ready("lu.go", 1'b1); tick();
    chk_out("lu.add", I_ADD_D, 16'h3102, c_add, 1'b0);
    chk_stall("lu.cnt_final", 2);

    // Independent ADD behind a load does not stall
    drive(1'b1, I_LDR3, 16'h3200); tick();
    drive(1'b1, I_ADD_N, 16'h3202); chk_ready("ind.rdy", 1'b1); tick();
    chk_out("ind.add", I_ADD_N, 16'h3202, c_add, 1'b0);
    chk_stall("ind.cnt", 2);
    drive(1'b0, '0, '0); tick(); tick();

    // STR reading R5 right after LDR R5
    drive(1'b1, I_LDR5, 16'h3300); tick();
    drive(1'b1, I_STR5, 16'h3302); chk_ready("str.stall1", 1'b0); tick();
    chk_ready("str.stall2", 1'b0); tick();
    chk_ready("str.go", 1'b1); tick();
    chk_out("str", I_STR5, 16'h3302, c_str, 1'b0);
    chk_stall("str.cnt", 4);

    // Backpressure: entry held, no acceptance, stall count frozen
    out_ready = 1'b0;
    drive(1'b1, I_ADD_R, 16'h3400);
    for (int i = 0; i < 4; i++) begin
      chk_ready("bp.rdy", 1'b0);
      tick();
      chk_out("bp.hold", I_STR5, 16'h3302, c_str, 1'b0);
      chk_stall("bp.cnt", 4);
    end
    out_ready = 1'b1;
    #1;
    chk_ready("bp.release", 1'b1); tick();
    chk_out("bp.add", I_ADD_R, 16'h3400, c_add, 1'b0);

    // Flush while a dependent ADD is stalled behind an LDR
    drive(1'b1, I_LDR3, 16'h3500); tick();
    out_ready = 1'b0;
    flush     = 1'b1;
    drive(1'b1, I_ADD_D, 16'h3502); chk_ready("fl.rdy", 1'b0); tick();
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk_stall("fl.cnt", 4);
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk_ready("fl.sb_clear", 1'b1); tick();
    chk_out("fl.add", I_ADD_D, 16'h3502, c_add, 1'b0);

    // Unsupported opcode
    drive(1'b1, I_ILL, 16'h3600); chk_ready("ill.rdy", 1'b1); tick();
    chk_out("ill", I_ILL, 16'h3600, '0, 1'b1);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, I_LDR3, 16'h3700); tick();
    drive(1'b1, I_ADD_D, 16'h3702); chk_ready("rst.stall", 1'b0); tick();
    chk_stall("rst.pre", 5);
    reset_n = 1'b0;
    #1;
    chk_zero("rst.mid");
    chk_ready("rst.rdy", 1'b1);
    reset_n = 1'b1;
    tick();
    chk_out("rst.add", I_ADD_D, 16'h3702, c_add, 1'b0);
    chk_stall("rst.cnt", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_decode_stage.md
# lc3b_decode_stage

Registered, handshaked decode stage for the pipelined LC-3b datapath. It sits between instruction fetch and execute. It decodes each instruction into an `lc3b_control_word` and holds the result in a one-entry pipeline register. It also tracks load results that are still in flight and stalls any dependent instruction until they complete. The block adds flush, illegal-opcode flagging and a stall counter, none of which the purely combinational control ROM provides.

## Interface
Parameters:
- `WORD_W`, default 16: instruction and PC width.
- `LOAD_LAT`, default 2, legal range 1..7: number of cycles a load's destination register stays pending after the load is accepted.
- `ILLEGAL_FLAG`, default 1: when 1, unsupported opcodes assert `out_illegal`; when 0, `out_illegal` is tied to 0.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch is presenting an instruction.
- `in_ready` out 1: the stage accepts the presented instruction this cycle.
- `in_inst` in `WORD_W`: instruction word.
- `in_pc` in `WORD_W`: PC of that instruction.
- `flush` in 1: discard the held entry and all pending-load state.
- `out_valid` out 1: the output register holds a valid entry.
- `out_ready` in 1: execute consumes the entry this cycle.
- `out_inst` out `WORD_W`: registered instruction.
- `out_pc` out `WORD_W`: registered PC.
- `out_ctrl` out `lc3b_control_word`: registered control word.
- `out_illegal` out 1: the registered opcode is unsupported.
- `stall_cycles` out `CNT_W`: saturating count of hazard-stall cycles.

## Operation
Decode defaults, applied before any opcode-specific value:
- `opcode` = `inst[15:12]`; `mem_byte_enable` = 2'b11; `alu_op` = `alu_add`.
- Every other field is 0.

Per-opcode control values:
- ADD / AND: `alu_op` = add / and; `load_regfile` = 1; `load_cc` = 1; `alumux_sel` = 2'b10 when `inst[5]` = 1.
- NOT: `alu_op` = `alu_not`; `load_regfile` = 1; `load_cc` = 1.
- LDR: `alumux_sel` = 2'b01; `load_mar` = 1; `mdrmux_sel` = 2'b01; `load_mdr` = 1; `mem_read` = 1; `regfilemux_sel` = 3'b001; `load_regfile` = 1; `load_cc` = 1.
- STR: `alumux_sel` = 2'b01; `load_mar` = 1; `mdrmux_sel` = 2'b11; `storemux_sel_two` = 1; `mem_write` = 1.
- BR: defaults only.
- SHF: `regfilemux_sel` = 3'b101; `load_regfile` = 1.
- Any other opcode: whole control word = 0; `out_illegal` = `ILLEGAL_FLAG`.

Source registers checked for hazards (R0 is an ordinary register, not special-cased):
- ADD / AND: `inst[8:6]`, plus `inst[2:0]` when `inst[5]` = 0.
- NOT, LDR, SHF: `inst[8:6]`.
- STR: `inst[8:6]` and `inst[11:9]`.
- BR: condition codes; BR stalls while any register is pending.
- Illegal opcodes: no sources.

Scoreboard:
- Eight countdown counters of 3 bits, one per register. A register is pending while its counter is nonzero.
- When an LDR is accepted, the counter for its destination `inst[11:9]` is loaded with `LOAD_LAT`.
- Every counter that is nonzero and not being loaded that cycle decrements every cycle, independent of `out_ready`.
- If a load and a decrement hit the same counter in the same cycle, the load wins.

Hazard and handshake:
- `hazard` = `in_valid` and the incoming instruction has at least one pending source.
- `in_ready` = (!`out_valid` | `out_ready`) & !`hazard` & !`flush`.
- Accept = `in_valid` & `in_ready`. On accept, the output register captures the instruction, PC, decoded control word and illegal flag, and `out_valid` is set to 1.
- If `out_ready` = 1 and there is no accept, `out_valid` goes to 0 on the next edge (bubble).
- `stall_cycles` increments in every cycle where `hazard` = 1 and `flush` = 0, saturating at all-ones.

Flush:
- Takes priority over everything else.
- Next edge: `out_valid` = 0 and all scoreboard counters = 0.
- No instruction is accepted in the flush cycle.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when there are no hazards and `out_ready` = 1.
- All outputs are registered except `in_ready`, which is combinational from `in_valid`, `in_inst`, `out_valid`, `out_ready`, `flush` and the scoreboard.
- With `out_ready` = 0, the held entry stays stable and `in_ready` = 0.
- Load-use spacing: an LDR accepted at edge N blocks a dependent instruction, which is accepted at edge N+`LOAD_LAT`+1. With `LOAD_LAT` = 2 this leaves exactly 2 bubbles between back-to-back dependent instructions.
- Reset (`reset_n` = 0, at any time including mid-stall), effective immediately:
  - `out_valid`, `out_inst`, `out_pc`, `out_ctrl`, `out_illegal`, `stall_cycles` = 0.
  - All scoreboard counters = 0.

## Test plan
- Reset, then a back-to-back stream of ADD, AND, NOT, SHF, BR with `out_ready` = 1 → one entry out per cycle, 1-cycle latency; ADD with `inst[5]` = 1 has `alumux_sel` = 2'b10; SHF has `regfilemux_sel` = 3'b101.
- LDR R3, then ADD R1,R3,R2, with `LOAD_LAT` = 2 → `in_ready` low for 2 cycles, ADD accepted on the 3rd cycle, `stall_cycles` = 2; same sequence with an independent ADD R1,R4,R2 → no stall.
- STR whose source `inst[11:9]` = R5, immediately after LDR R5 → stall; STR emits `mdrmux_sel` = 2'b11, `storemux_sel_two` = 1, `mem_write` = 1.
- Hold `out_ready` = 0 for 4 cycles with `in_valid` high → outputs stable, `in_ready` = 0, `stall_cycles` unchanged.
- Assert `flush` while a dependent ADD is stalled behind an LDR → next cycle `out_valid` = 0 and the scoreboard is clear; the ADD is accepted the cycle after `flush` drops.
- Opcode 4'b1000 with `ILLEGAL_FLAG` = 1 → `out_ctrl` = 0, `out_illegal` = 1; drive `reset_n` low mid-stall → all outputs 0 immediately.
